game_input_ctrl: RTL and testbench
==================================

# game_input_ctrl

Input conditioner for the Tang 4K breakout game. It takes the three raw, active-low, bouncing push-button pads and produces clean signals for the game-logic stage that sits directly downstream: the two debounced paddle levels (`btn[1:0]`) and the run level (`str`). Each channel has a two-flop synchroniser and a counter-based debounce FSM. A start/run latch then turns start-button presses into the `str` level.

## Interface
- `DEBOUNCE_CYC`, 270000: stable cycles required before a level change is accepted (10 ms at 27 MHz); legal range ≥ 2.
- `CNT_W`, 20: debounce counter width; must hold `DEBOUNCE_CYC-1`.

- `clk`  in  1  system/pixel-domain clock.
- `reset`  in  1  asynchronous, active-low reset.
- `key_n`  in  3  raw pads, active-low, asynchronous: [0] right, [1] left, [2] start.
- `btn`  out  2  debounced active-high levels: [0] right, [1] left.
- `press`  out  3  one-cycle pulse per channel on each accepted press.
- `str`  out  1  run level consumed by game logic.

## Operation
- Synchroniser: two flops per channel; reset value 1 (released). The synchroniser output `s` is inverted to active-high `p`.
- Per-channel FSM: IDLE, WAIT_PRESS, PRESSED, WAIT_REL.
  - IDLE: if `p`=1, go to WAIT_PRESS with cnt←0.
  - WAIT_PRESS: if `p`=0, go to IDLE. Else if cnt==`DEBOUNCE_CYC-1`, go to PRESSED and assert `press` for that cycle. Else cnt++.
  - PRESSED: if `p`=0, go to WAIT_REL with cnt←0.
  - WAIT_REL: if `p`=1, go to PRESSED. Else if cnt==`DEBOUNCE_CYC-1`, go to IDLE. Else cnt++.
- Channel level = 1 in PRESSED and WAIT_REL; `btn[1:0]` = levels of channels 1..0, registered with the state.
- Any bounce during a WAIT state returns the FSM to its previous stable state. The counter restarts on the next entry.
- cnt saturates and never wraps. Compare is unsigned, `CNT_W` bits.
- `str` latch: updated from `press[2]` (see Configuration). Left and right both pressed: both `btn` bits high; the downstream stage resolves the priority.
- Reset mid-debounce: everything returns to IDLE, cnt=0, and no `press` pulse is emitted.

## Timing
- Reset values: `btn`=0, `press`=0, `str`=0, all FSMs IDLE, synchronisers 1.
- Press latency, for a clean low on `key_n` first sampled at edge 0:
  - `p` is high after edge 2.
  - WAIT_PRESS is entered at edge 3.
  - PRESSED, `btn`/`press` high, at edge 3+`DEBOUNCE_CYC`.
- Release latency is symmetric: `btn` falls at edge 3+`DEBOUNCE_CYC` after the release is first sampled.
- `press` is high for exactly one cycle per accepted press. It is never reasserted while the button is held.
- `str` changes on the edge after the `press[2]` cycle, i.e. 1 cycle after the pulse.
- Glitches shorter than `DEBOUNCE_CYC`+1 cycles never change `btn`, `press` or `str`.

## Configuration
- `GAME_PAUSE_EN` defined: each `press[2]` toggles `str`, giving run/pause.
- Not defined: `press[2]` sets `str`=1, and it stays 1 until `reset`. Further presses have no effect.

## Structure
- Shared package `game_pkg`:
  - FSM state encoding: IDLE=2'd0, WAIT_PRESS=2'd1, PRESSED=2'd2, WAIT_REL=2'd3.
  - Channel index constants: KEY_RIGHT=0, KEY_LEFT=1, KEY_START=2.
- Sub-module `debounce_cell`: one channel (synchroniser, FSM, counter). It outputs `level` and `press` and is instantiated three times.
- The top level holds only the instances, the `btn` mapping and the `str` latch.

## Test plan
All scenarios use `DEBOUNCE_CYC`=4.
1. Reset asserted mid-run with `key_n`=3'b111 → all outputs 0 during reset and after release.
2. `key_n[0]` low from edge 0, held → `btn[0]` and `press[0]` rise at edge 7, `press[0]` falls at edge 8, `btn[0]` stays 1. Release → `btn[0]` falls 7 edges later.
3. `key_n[1]` low for 3 cycles, high for 2, repeated 5× → `btn[1]` stays 0 and `press[1]` never pulses.
4. With `GAME_PAUSE_EN`, two clean start presses → `str` 0→1 at edge 8, then back to 0 after the second press. Without the macro, `str` stays 1.
5. Both `key_n[1:0]` pressed simultaneously → `btn`=2'b11 at edge 7 with both `press` bits pulsing in the same cycle.
6. Reset asserted 2 cycles into WAIT_PRESS → no `press` pulse and `btn`=0. After reset releases with the key still held, `btn` rises 7 edges later.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the breakout input conditioner.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_PRESS = 2'd1,
    PRESSED    = 2'd2,
    WAIT_REL   = 2'd3
  } dbnc_state_t;

  localparam int KEY_RIGHT = 0;
  localparam int KEY_LEFT  = 1;
  localparam int KEY_START = 2;

endpackage

// File: rtl/game_input_ctrl_if.sv
// Pad inputs and conditioned outputs between the board pins and game logic.
interface game_input_ctrl_if;
  logic [2:0] key_n;
  logic [1:0] btn;
  logic [2:0] press;
  logic       str;

  modport master (output key_n, input btn, press, str);
  modport slave  (input key_n, output btn, press, str);
endinterface

// File: rtl/game_input_ctrl_debounce_cell.sv
// One push-button channel: two-flop synchroniser, registered inversion and
// counter-based debounce FSM producing a stable level and a press pulse.
module debounce_cell
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 270000,
  parameter int CNT_W        = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  logic [1:0]       sync_q;
  logic             p_q;
  dbnc_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // p is registered so the FSM sees a press two edges after first sampling
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '1;
      p_q     <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_n};
      p_q     <= ~sync_q[1];
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (p_q) begin
          state_d = WAIT_PRESS;
          cnt_d   = '0;
        end
      end
      WAIT_PRESS: begin
        if (!p_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          press_d = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!p_q) begin
          state_d = WAIT_REL;
          cnt_d   = '0;
        end
      end
      WAIT_REL: begin
        if (p_q) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign level = (state_q == PRESSED) || (state_q == WAIT_REL);
  assign press = press_q;

endmodule

// File: rtl/game_input_ctrl.sv
// Input conditioner top: three debounce channels, paddle mapping, run latch.
// Define GAME_PAUSE_EN to make each start press toggle run/pause.
module game_input_ctrl
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 270000,
  parameter int CNT_W        = 20
) (
  input  logic             clk,
  input  logic             reset,
  game_input_ctrl_if.slave io
);

  logic [2:0] level;
  logic [2:0] press;
  logic       str_q;

  debounce_cell #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .CNT_W(CNT_W)) u_right (
    .clk(clk), .reset(reset), .key_n(io.key_n[KEY_RIGHT]),
    .level(level[KEY_RIGHT]), .press(press[KEY_RIGHT])
  );

  debounce_cell #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .CNT_W(CNT_W)) u_left (
    .clk(clk), .reset(reset), .key_n(io.key_n[KEY_LEFT]),
    .level(level[KEY_LEFT]), .press(press[KEY_LEFT])
  );

  debounce_cell #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .CNT_W(CNT_W)) u_start (
    .clk(clk), .reset(reset), .key_n(io.key_n[KEY_START]),
    .level(level[KEY_START]), .press(press[KEY_START])
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      str_q <= 1'b0;
    end else begin
`ifdef GAME_PAUSE_EN
      str_q <= str_q ^ press[KEY_START];
`else
      if (press[KEY_START]) str_q <= 1'b1;
`endif
    end
  end

  // the start channel's level is unused; it only drives the run latch
  assign io.btn   = {level[KEY_LEFT], level[KEY_RIGHT]};
  assign io.press = press;
  assign io.str   = str_q;

endmodule

// File: tb/tb_game_input_ctrl.sv
// Directed self-checking bench for game_input_ctrl with DEBOUNCE_CYC=4.
module tb_game_input_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic seen;

  game_input_ctrl_if io ();

  game_input_ctrl #(.DEBOUNCE_CYC(4), .CNT_W(3)) dut (
    .clk(clk),
    .reset(reset),
    .io(io)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_btn"}, {6'd0, io.btn}, 8'h00);
    chk({tag, "_press"}, {5'd0, io.press}, 8'h00);
    chk({tag, "_str"}, {7'd0, io.str}, 8'h00);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    // 1: reset with keys released, then reset mid-run
    io.key_n = 3'b111;
    reset = 1'b0;
    tick();
    outs_zero("rst_initial");
    reset = 1'b1;
    repeat (5) tick();
    reset = 1'b0;
    #1;
    outs_zero("rst_during");
    tick();
    reset = 1'b1;
    repeat (10) tick();
    outs_zero("rst_after");

    // 2: clean right press, hold, release
    io.key_n = 3'b110;
    for (int k = 0; k <= 8; k++) begin
      tick();
      chk($sformatf("press_btn_e%0d", k), {6'd0, io.btn}, (k >= 7) ? 8'h01 : 8'h00);
      chk($sformatf("press_pulse_e%0d", k), {5'd0, io.press}, (k == 7) ? 8'h01 : 8'h00);
    end
    repeat (10) tick();
    chk("hold_btn", {6'd0, io.btn}, 8'h01);
    chk("hold_press", {5'd0, io.press}, 8'h00);
    io.key_n = 3'b111;
    for (int k = 0; k <= 8; k++) begin
      tick();
      chk($sformatf("rel_btn_e%0d", k), {6'd0, io.btn}, (k >= 7) ? 8'h00 : 8'h01);
      chk($sformatf("rel_pulse_e%0d", k), {5'd0, io.press}, 8'h00);
    end

    // 3: bouncing left key never accepted
    do_reset();
    seen = 1'b0;
    for (int r = 0; r < 5; r++) begin
      io.key_n = 3'b101;
      repeat (3) begin tick(); seen = seen | io.btn[1] | io.press[1]; end
      io.key_n = 3'b111;
      repeat (2) begin tick(); seen = seen | io.btn[1] | io.press[1]; end
    end
    repeat (10) begin tick(); seen = seen | io.btn[1] | io.press[1]; end
    chk("bounce_seen", {7'd0, seen}, 8'h00);
    chk("bounce_btn", {6'd0, io.btn}, 8'h00);

    // 4: two start presses drive the run latch
    do_reset();
    io.key_n = 3'b011;
    repeat (8) tick();
    chk("str_e7", {7'd0, io.str}, 8'h00);
    chk("str_press_e7", {5'd0, io.press}, 8'h04);
    tick();
    chk("str_e8", {7'd0, io.str}, 8'h01);
    io.key_n = 3'b111;
    repeat (12) tick();
    chk("str_released", {7'd0, io.str}, 8'h01);
    io.key_n = 3'b011;
    repeat (9) tick();
`ifdef GAME_PAUSE_EN
    chk("str_second", {7'd0, io.str}, 8'h00);
`else
    chk("str_second", {7'd0, io.str}, 8'h01);
`endif
    io.key_n = 3'b111;
    repeat (12) tick();

    // 5: simultaneous left and right
    do_reset();
    io.key_n = 3'b100;
    repeat (7) tick();
    chk("both_e6_btn", {6'd0, io.btn}, 8'h00);
    tick();
    chk("both_e7_btn", {6'd0, io.btn}, 8'h03);
    chk("both_e7_press", {5'd0, io.press}, 8'h03);
    tick();
    chk("both_e8_press", {5'd0, io.press}, 8'h00);
    io.key_n = 3'b111;
    repeat (12) tick();

    // 6: reset two cycles into WAIT_PRESS, key kept held
    do_reset();
    io.key_n = 3'b110;
    seen = 1'b0;
    repeat (6) begin tick(); seen = seen | io.press[0]; end
    reset = 1'b0;
    #1;
    outs_zero("midrst_during");
    repeat (4) begin tick(); seen = seen | io.press[0]; end
    chk("midrst_nopulse", {7'd0, seen}, 8'h00);
    chk("midrst_btn", {6'd0, io.btn}, 8'h00);
    reset = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      tick();
      chk($sformatf("midrst_btn_e%0d", k), {6'd0, io.btn}, (k >= 7) ? 8'h01 : 8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
